l1_trigger_ctrl: RTL and testbench

- Single-clock L1 trigger control block.
- Takes per-cycle beam trigger flags from the beamformer, applies a software-programmable beam mask, run gating and holdoff.
- Emits one trigger word per accepted event on a minimal AXI4-Stream master.
- Register access is through a 15-bit/32-bit Wishbone classic slave on the same clock. Sits between beamformer and trigger-collection logic.

---
 rtl/l1_trigger_pkg.sv | 25 ++
 rtl/l1_trigger_wb_regs.sv | 103 ++++++++++
 rtl/l1_trigger_ctrl.sv | 133 +++++++++++++
 tb/tb_l1_trigger_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_trigger_pkg.sv
// Shared constants and types for the L1 trigger control block.
package l1_trigger_pkg;

    // Register byte offsets in the Wishbone window.
    localparam logic [14:0] REG_ID     = 15'h2000;
    localparam logic [14:0] REG_STATUS = 15'h2004;
    localparam logic [14:0] REG_MASK   = 15'h2008;
    localparam logic [14:0] REG_CTRL   = 15'h200C;
    localparam logic [14:0] REG_ACCEPT = 15'h2010;
    localparam logic [14:0] REG_DROP   = 15'h2014;

    localparam logic [31:0] ID_VALUE  = 32'h4C315452;
    localparam int          APPLY_BIT = 31;

    // Trigger word layout: timestamp in the upper half, masked beams below.
    localparam int TS_W           = 16;
    localparam int TDATA_TS_LSB   = 16;
    localparam int TDATA_BEAM_LSB = 0;

    typedef enum logic {
        RUN_STOPPED = 1'b0,
        RUN_RUNNING = 1'b1
    } run_state_e;

endpackage

// File: rtl/l1_trigger_wb_regs.sv
// Wishbone classic slave: address decode, staged/active beam mask,
// holdoff register and the one-cycle mask apply pulse.
module l1_trigger_wb_regs
    import l1_trigger_pkg::*;
#(
    parameter int NBEAM     = 16,
    parameter int HOLDOFF_W = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_we_i,
    input  logic [14:0]          wb_adr_i,
    input  logic [31:0]          wb_dat_i,
    output logic [31:0]          wb_dat_o,
    output logic                 wb_ack_o,
    input  logic                 running_i,
    input  logic                 tvalid_i,
    input  logic [31:0]          accept_cnt_i,
    input  logic [31:0]          drop_cnt_i,
    output logic [NBEAM-1:0]     active_mask_o,
    output logic [HOLDOFF_W-1:0] holdoff_o
);

    logic                 ack_q, ack_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [NBEAM-1:0]     staged_q, staged_d;
    logic [NBEAM-1:0]     active_q, active_d;
    logic [HOLDOFF_W-1:0] holdoff_q, holdoff_d;
    logic                 apply_q, apply_d;
    logic                 req;
    logic [14:0]          word_adr;
    logic                 unused_bits;

    // A new access is only taken while ack is low, so ack is one cycle wide.
    assign req      = wb_cyc_i & wb_stb_i & ~ack_q;
    assign word_adr = {wb_adr_i[14:2], 2'b00};

    // Byte-lane bits and write-data bits with no register behind them.
    assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i};

    // Decode, register updates and the apply pulse.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        ack_d     = req;
        rdata_d   = '0;
        staged_d  = staged_q;
        holdoff_d = holdoff_q;
        apply_d   = 1'b0;
        // Apply lands one cycle after the ack, so a hit in the ack cycle still sees the old mask.
        active_d  = apply_q ? staged_q : active_q;

        if (req && !wb_we_i) begin
            unique case (word_adr)
                REG_ID:     rdata_d = ID_VALUE;
                REG_STATUS: rdata_d[1:0] = {tvalid_i, running_i};
                REG_MASK:   rdata_d[NBEAM-1:0] = staged_q;
                REG_CTRL:   rdata_d[HOLDOFF_W-1:0] = holdoff_q;
                REG_ACCEPT: rdata_d = accept_cnt_i;
                REG_DROP:   rdata_d = drop_cnt_i;
                default:    rdata_d = '0;
            endcase
        end

        if (req && wb_we_i) begin
            unique case (word_adr)
                REG_MASK: staged_d = wb_dat_i[NBEAM-1:0];
                REG_CTRL: begin
                    holdoff_d = wb_dat_i[HOLDOFF_W-1:0];
                    apply_d   = wb_dat_i[APPLY_BIT];
                end
                default: ;
            endcase
        end
    end

    // Register state with synchronous reset; masks reset to all-masked.
    always_ff @(posedge wb_clk_i) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (wb_rst_i) begin
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            staged_q  <= '1;
            active_q  <= '1;
            holdoff_q <= '0;
            apply_q   <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            staged_q  <= staged_d;
            active_q  <= active_d;
            holdoff_q <= holdoff_d;
            apply_q   <= apply_d;
        end
    end

    assign wb_ack_o      = ack_q;
    assign wb_dat_o      = rdata_q;
    assign active_mask_o = active_q;
    assign holdoff_o     = holdoff_q;

endmodule

// File: rtl/l1_trigger_ctrl.sv
// L1 trigger control: beam masking, run gating, holdoff and the
// AXI4-Stream trigger word output, with a Wishbone register slave.
module l1_trigger_ctrl
    import l1_trigger_pkg::*;
#(
    parameter int NBEAM     = 16,
    parameter int HOLDOFF_W = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [14:0]      wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    input  logic [3:0]       wb_sel_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    output logic             wb_err_o,
    output logic             wb_rty_o,
    input  logic [NBEAM-1:0] beam_trig_i,
    input  logic             runrst_i,
    input  logic             runstop_i,
    output logic [31:0]      m_trig_tdata,
    output logic             m_trig_tvalid,
    input  logic             m_trig_tready
);

    run_state_e           state_q, state_d;
    logic [TS_W-1:0]      ts_q, ts_d;
    logic [HOLDOFF_W-1:0] timer_q, timer_d;
    logic [31:0]          accept_q, accept_d;
    logic [31:0]          drop_q, drop_d;
    logic                 tvalid_q, tvalid_d;
    logic [31:0]          tdata_q, tdata_d;

    logic [NBEAM-1:0]     active_mask;
    logic [HOLDOFF_W-1:0] holdoff;
    logic [NBEAM-1:0]     masked_beam;
    logic                 running, hit, slot_free, accept, drop;
    logic                 unused_sel;

    assign wb_err_o   = 1'b0;
    assign wb_rty_o   = 1'b0;
    assign unused_sel = ^wb_sel_i;

    l1_trigger_wb_regs #(
        .NBEAM     (NBEAM),
        .HOLDOFF_W (HOLDOFF_W)
    ) u_regs (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_i      (wb_rst_i),
        .wb_cyc_i      (wb_cyc_i),
        .wb_stb_i      (wb_stb_i),
        .wb_we_i       (wb_we_i),
        .wb_adr_i      (wb_adr_i),
        .wb_dat_i      (wb_dat_i),
        .wb_dat_o      (wb_dat_o),
        .wb_ack_o      (wb_ack_o),
        .running_i     (running),
        .tvalid_i      (tvalid_q),
        .accept_cnt_i  (accept_q),
        .drop_cnt_i    (drop_q),
        .active_mask_o (active_mask),
        .holdoff_o     (holdoff)
    );

    // A run-reset cycle clears the run bookkeeping, so it never emits a trigger.
    assign masked_beam = beam_trig_i & ~active_mask;
    assign running     = (state_q == RUN_RUNNING);
    assign hit         = (|masked_beam) & running & (timer_q == '0) & ~runrst_i;
    assign slot_free   = ~tvalid_q | m_trig_tready;
    assign accept      = hit & slot_free;
    assign drop        = hit & ~slot_free;

    // Next-state for run control, timestamp, holdoff, counters and output slot.
    always_comb begin
        state_d  = state_q;
        ts_d     = running ? ts_q + 16'd1 : ts_q;
        timer_d  = (timer_q != '0) ? timer_q - HOLDOFF_W'(1) : timer_q;
        accept_d = accept ? accept_q + 32'd1 : accept_q;
        drop_d   = drop ? drop_q + 32'd1 : drop_q;
        tvalid_d = tvalid_q & ~m_trig_tready;
        tdata_d  = tdata_q;

        if (accept) begin
            timer_d  = holdoff;
            tvalid_d = 1'b1;
            tdata_d  = '0;
            tdata_d[TDATA_TS_LSB +: TS_W]     = ts_q;
            tdata_d[TDATA_BEAM_LSB +: NBEAM] = masked_beam;
        end

        if (runrst_i) begin
            ts_d     = '0;
            timer_d  = '0;
            accept_d = '0;
            drop_d   = '0;
        end

        // Stop wins when both pulses coincide; a pending tvalid is never retracted.
        if (runstop_i) begin
            state_d = RUN_STOPPED;
        end else if (runrst_i) begin
            state_d = RUN_RUNNING;
        end
    end

    // Trigger-path state register with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= RUN_STOPPED;
            ts_q     <= '0;
            timer_q  <= '0;
            accept_q <= '0;
            drop_q   <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ts_q     <= ts_d;
            timer_q  <= timer_d;
            accept_q <= accept_d;
            drop_q   <= drop_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
        end
    end

    assign m_trig_tvalid = tvalid_q;
    assign m_trig_tdata  = tdata_q;

endmodule

// File: tb/tb_l1_trigger_ctrl.sv
// Self-checking bench for l1_trigger_ctrl: directed scenarios followed by
// randomized traffic, all checked against a cycle-count based reference model.
module tb_l1_trigger_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [14:0] adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o, wb_rty_o;
    logic [15:0] beam;
    logic        runrst, runstop;
    logic [31:0] m_trig_tdata;
    logic        m_trig_tvalid;
    logic        tready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    l1_trigger_ctrl #(.NBEAM(16), .HOLDOFF_W(16)) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .wb_cyc_i      (cyc),
        .wb_stb_i      (stb),
        .wb_we_i       (we),
        .wb_adr_i      (adr),
        .wb_dat_i      (dat_w),
        .wb_sel_i      (sel),
        .wb_dat_o      (wb_dat_o),
        .wb_ack_o      (wb_ack_o),
        .wb_err_o      (wb_err_o),
        .wb_rty_o      (wb_rty_o),
        .beam_trig_i   (beam),
        .runrst_i      (runrst),
        .runstop_i     (runstop),
        .m_trig_tdata  (m_trig_tdata),
        .m_trig_tvalid (m_trig_tvalid),
        .m_trig_tready (tready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model. The holdoff is tracked as the absolute cycle from which
    // a new trigger is allowed; the output slot is a single pending word.
    longint      m_cyc, m_ready;
    logic        m_run, m_valid, m_ack, m_ack_rd, m_apply_pend;
    logic [15:0] m_ts, m_staged, m_active, m_holdoff;
    logic [31:0] m_data, m_acc, m_drop, m_rdata;

    task automatic model_eval();
        logic [15:0] masked;
        logic        hit, slot_free, req;
        if (rst) begin
            m_run = 0; m_ts = 0; m_staged = 16'hFFFF; m_active = 16'hFFFF;
            m_holdoff = 0; m_ready = 0; m_valid = 0; m_data = 0; m_acc = 0;
            m_drop = 0; m_ack = 0; m_ack_rd = 0; m_rdata = 0; m_apply_pend = 0;
            m_cyc++;
            return;
        end
        masked    = beam & ~m_active;
        hit       = (masked != 0) && m_run && (m_cyc >= m_ready) && !runrst;
        slot_free = !m_valid || tready;
        req       = cyc && stb && !m_ack;

        m_ack_rd = req && !we;
        m_rdata  = 0;
        if (req && !we) begin
            case ({adr[14:2], 2'b00})
                15'h2000: m_rdata = 32'h4C315452;
                15'h2004: m_rdata = {30'd0, m_valid, m_run};
                15'h2008: m_rdata = {16'd0, m_staged};
                15'h200C: m_rdata = {16'd0, m_holdoff};
                15'h2010: m_rdata = m_acc;
                15'h2014: m_rdata = m_drop;
                default:  m_rdata = 0;
            endcase
        end

        if (m_valid && tready) m_valid = 0;
        if (hit && slot_free) begin
            m_valid = 1;
            m_data  = {m_ts, masked};
            m_acc   = m_acc + 1;
            m_ready = m_cyc + longint'(m_holdoff) + 1;
        end else if (hit) begin
            m_drop = m_drop + 1;
        end

        if (m_run) m_ts = m_ts + 1;
        if (runrst) begin
            m_ts = 0; m_acc = 0; m_drop = 0; m_ready = 0;
        end
        if (runstop) m_run = 0;
        else if (runrst) m_run = 1;

        if (m_apply_pend) m_active = m_staged;
        m_apply_pend = 0;
        if (req && we) begin
            if ({adr[14:2], 2'b00} == 15'h2008) m_staged = dat_w[15:0];
            if ({adr[14:2], 2'b00} == 15'h200C) begin
                m_holdoff    = dat_w[15:0];
                m_apply_pend = dat_w[31];
            end
        end
        m_ack = req;
        m_cyc++;
    endtask

    // One clock: advance the model, let the edge pass, compare on the falling edge.
    task automatic step();
        model_eval();
        @(posedge clk);
        @(negedge clk);
        check("tvalid", {31'd0, m_trig_tvalid}, {31'd0, m_valid});
        if (m_valid) check("tdata", m_trig_tdata, m_data);
        check("ack", {31'd0, wb_ack_o}, {31'd0, m_ack});
        if (m_ack && m_ack_rd) check("rdata", wb_dat_o, m_rdata);
    endtask

    task automatic wb_access(input logic is_wr, input logic [14:0] a,
                             input logic [31:0] d, output logic [31:0] rd);
        int n = 0;
        cyc = 1; stb = 1; we = is_wr; adr = a; dat_w = d;
        step();
        while (!wb_ack_o && n < 8) begin
            step();
            n++;
        end
        if (!wb_ack_o) check("wb_ack_timeout", {31'd0, wb_ack_o}, 32'd1);
        rd = wb_dat_o;
        cyc = 0; stb = 0; we = 0;
        step();
    endtask

    task automatic wb_write(input logic [14:0] a, input logic [31:0] d);
        logic [31:0] unused_rd;
        wb_access(1'b1, a, d, unused_rd);
    endtask

    task automatic wb_read(input logic [14:0] a, output logic [31:0] rd);
        wb_access(1'b0, a, 32'd0, rd);
    endtask

    task automatic pulse(input logic do_rst, input logic do_stop);
        runrst = do_rst; runstop = do_stop;
        step();
        runrst = 0; runstop = 0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [15:0] ts_list[$];
        m_cyc = 0;
        rst = 1; cyc = 0; stb = 0; we = 0; adr = 0; dat_w = 0; sel = 4'hF;
        beam = 0; runrst = 0; runstop = 0; tready = 1;
        repeat (3) step();
        check("rst_tdata", m_trig_tdata, 32'd0);
        check("rst_wbdat", wb_dat_o, 32'd0);
        check("rst_err_rty", {30'd0, wb_err_o, wb_rty_o}, 32'd0);
        rst = 0;
        step();

        // Identification and reset mask.
        wb_read(15'h2000, rd); check("id", rd, 32'h4C315452);
        wb_read(15'h2008, rd); check("mask_rst", rd, 32'h0000FFFF);

        // Reset mask blocks every beam.
        pulse(1, 0);
        beam = 16'h0001; repeat (3) step(); beam = 0;
        check("masked_no_tvalid", {31'd0, m_trig_tvalid}, 32'd0);
        wb_read(15'h2010, rd); check("acc_zero", rd, 32'd0);

        // Unmask and apply, then a single trigger.
        wb_write(15'h2008, 32'h0);
        wb_write(15'h200C, 32'h8000_0000);
        beam = 16'h0001; step(); beam = 0;
        check("first_tvalid", {31'd0, m_trig_tvalid}, 32'd1);
        check("first_beams", {16'd0, m_trig_tdata[15:0]}, 32'h0001);
        step();
        wb_read(15'h2010, rd); check("acc_one", rd, 32'd1);

        // Staged mask has no effect until applied.
        wb_write(15'h2008, 32'hFFFF_FFFF);
        beam = 16'h0001; step(); beam = 0;
        check("staged_no_effect", {31'd0, m_trig_tvalid}, 32'd1);
        wb_write(15'h200C, 32'h8000_0000);
        beam = 16'h0001; repeat (3) step(); beam = 0;
        check("applied_mask", {31'd0, m_trig_tvalid}, 32'd0);

        // Holdoff 4: one trigger every fifth cycle.
        wb_write(15'h2008, 32'h0);
        wb_write(15'h200C, 32'h8000_0004);
        beam = 16'h0003; tready = 1;
        for (int i = 0; i < 26; i++) begin
            step();
            if (m_trig_tvalid) ts_list.push_back(m_trig_tdata[31:16]);
        end
        beam = 0;
        check("holdoff_count", (ts_list.size() >= 5) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 1; i < ts_list.size(); i++)
            check("holdoff_spacing", {16'd0, ts_list[i] - ts_list[i-1]}, 32'd5);

        // Back-pressure: word held, every further hit dropped.
        wb_write(15'h200C, 32'h8000_0000);
        pulse(1, 0);
        tready = 0; beam = 16'h0001;
        repeat (10) step();
        beam = 0;
        wb_read(15'h2010, rd); check("bp_acc", rd, 32'd1);
        wb_read(15'h2014, rd); check("bp_drop", rd, 32'd9);
        tready = 1; step();

        // Stop, then simultaneous reset/stop.
        pulse(0, 1);
        beam = 16'h00F0; repeat (5) step(); beam = 0;
        check("stopped_no_tvalid", {31'd0, m_trig_tvalid}, 32'd0);
        pulse(1, 1);
        wb_read(15'h2010, rd); check("both_acc", rd, 32'd0);
        wb_read(15'h2014, rd); check("both_drop", rd, 32'd0);
        wb_read(15'h2004, rd); check("both_running", {31'd0, rd[0]}, 32'd0);

        // Randomized traffic with register updates and run-control pulses.
        pulse(1, 0);
        for (int i = 0; i < 700; i++) begin
            int op;
            beam   = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0;
            tready = ($urandom_range(0, 3) != 0);
            op = $urandom_range(0, 99);
            if (op < 3)
                wb_write(15'h2008, $urandom & 32'h0000_0F3C);
            else if (op < 6)
                wb_write(15'h200C, {1'($urandom), 15'd0, 16'($urandom_range(0, 5))});
            else if (op < 10)
                wb_read({12'h200 + 12'($urandom_range(0, 6)), 3'($urandom_range(0, 1) * 4)}, rd);
            else if (op == 10)
                pulse(1, 0);
            else if (op == 11)
                pulse(0, 1);
            else
                step();
        end

        // Reset while a word is pending.
        beam = 0; tready = 1;
        pulse(1, 0);
        wb_write(15'h2008, 32'h0);
        wb_write(15'h200C, 32'h8000_0000);
        tready = 0; beam = 16'h0002; step(); beam = 0;
        check("pre_rst_tvalid", {31'd0, m_trig_tvalid}, 32'd1);
        rst = 1; step(); rst = 0;
        check("rst_drops_tvalid", {31'd0, m_trig_tvalid}, 32'd0);
        tready = 1; step();
        wb_read(15'h2008, rd); check("mask_after_rst", rd, 32'h0000FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
